stream_checker: RTL
===================

// Module: stream_checker
// PURPOSE
// Synthesizable sink end of the test-vector stream. Expected samples arrive through a valid/ready
// handshake and are buffered in a FIFO. Actual DUT samples arrive as valid strobes at sample rate.
// Each actual sample is compared with the FIFO head. The block counts samples, mismatches, orphan
// samples and missing samples, and raises done once a run is flushed.
// PARAMETERS
// DATA_W   16  width of expected/actual samples
// DEPTH    8   expected-sample FIFO depth (power of 2, >=2)
// CNT_W    32  width of sample/error counters
// TOL      0   absolute tolerance, used only when STREAM_CHECKER_TOL_EN is defined
// PORTS
// clk          in   1              single clock, all logic on posedge
// rst_n        in   1              asynchronous active-low reset
// start        in   1              pulse: clear stats and FIFO, enter RUN
// finish       in   1              pulse: last actual sample already presented, enter FLUSH
// exp_valid    in   1              expected sample valid
// exp_data     in   DATA_W         expected sample
// exp_ready    out  1              FIFO accepts expected sample
// act_valid    in   1              actual DUT sample strobe
// act_data     in   DATA_W         actual DUT sample
// mismatch     out  1              1-cycle pulse per erroneous actual sample
// total_cnt    out  CNT_W          actual samples checked
// err_cnt      out  CNT_W          mismatches + orphans + missing
// first_err    out  CNT_W          zero-based total_cnt index of first error
// err_seen     out  1              sticky: at least one error this run
// orphan       out  1              sticky: actual sample arrived with FIFO empty
// done         out  1              high while in DONE
// BEHAVIOUR
// - Reset (async, any time incl. mid-run): state=IDLE, FIFO empty, all outputs 0.
// - States:
//   - IDLE -start-> RUN
//   - RUN -finish-> FLUSH
//   - FLUSH -(1 cycle)-> DONE
//   - DONE -start-> RUN
//   - start in RUN/FLUSH restarts: clears stats and FIFO, then RUN. start has priority over finish.
// - exp_ready = (state==RUN) && !full, derived from registered occupancy.
//   - Full + pop in the same cycle does NOT admit a push.
//   - Push on exp_valid && exp_ready.
// - act_valid is honoured in RUN only and ignored in IDLE/FLUSH/DONE.
//   - FIFO non-empty: pop the head and compare.
//   - FIFO empty: orphan error. No bypass, even if a push happens in the same cycle.
// - Latency: compare result is registered. mismatch, total_cnt, err_cnt and first_err update
//   1 cycle after the act_valid edge.
// - Compare (macro off): error iff act_data != exp_head.
// - On error:
//   - err_cnt += 1
//   - if !err_seen: first_err = total_cnt before increment, err_seen = 1
// - FLUSH:
//   - err_cnt += FIFO occupancy (missing samples).
//   - If occupancy > 0 and !err_seen: first_err = total_cnt, err_seen = 1.
//   - FIFO cleared.
// - Counters saturate at all-ones, no wrap. The FIFO pointers wrap modulo DEPTH.
// - Outputs hold their values in DONE until start or reset.
// CONFIGURATION
// STREAM_CHECKER_TOL_EN defined:
// - Samples are treated as signed.
// - Error iff |act_data - exp_head| > TOL.
// - Difference computed at DATA_W+1 bits, so there is no overflow.
// Undefined: exact equality compare, and TOL is ignored.
// TESTING
// 1. Reset; start; push 4 exp {1,2,3,4}; act {1,2,3,4}; finish -> total_cnt=4, err_cnt=0,
//    err_seen=0, done=1 two cycles after finish.
// 2. Exp {10,20,30}, act {10,21,30} -> single mismatch pulse 1 cycle after 2nd act,
//    err_cnt=1, first_err=1.
// 3. Push DEPTH=8 exp with no act -> exp_ready=0. One act pop with exp_valid held -> no push
//    in the pop cycle, push next cycle.
// 4. act_valid with FIFO empty -> orphan=1, err_cnt=1, first_err=0. Exp 3 values, 1 act, finish
//    -> err_cnt +=2 in FLUSH.
// 5. Assert rst_n=0 mid-run with FIFO 5 deep -> all outputs 0 immediately, exp_ready=0 until
//    start. Counter preset near max -> saturates at 2^CNT_W-1.
// 6. TOL_EN, TOL=2: exp -5, act -3 -> no error; act -8 -> error. Without macro, act -3 -> error.

Source files
------------

// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
// stream_checker: FIFO-buffered expected vs. actual sample checker with stats.
// STREAM_CHECKER_TOL_EN: signed compare within +/-TOL instead of equality.
// Revision: 1.0
// ============================================================================
module stream_checker #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32,
  parameter int TOL    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              exp_valid_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              exp_ready_o,
  input  logic              act_valid_i,
  input  logic [DATA_W-1:0] act_data_i,
  output logic              mismatch_o,
  output logic [CNT_W-1:0]  total_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_o,
  output logic              err_seen_o,
  output logic              orphan_o,
  output logic              done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]   total_q, total_d, err_q, err_d, first_q, first_d;
  logic               seen_q, seen_d, orphan_q, orphan_d, mism_q, mism_d;

  logic               in_run, empty, push, pop, orph_ev, cmp_err, bad;
  logic [DATA_W-1:0]  head;
  logic [CNT_W:0]     flush_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_run      = (state_q == S_RUN);
  assign empty       = (count_q == '0);
  assign exp_ready_o = in_run && (count_q != FULL_CNT);
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = in_run && act_valid_i && !empty;
  assign orph_ev     = in_run && act_valid_i && empty;
  assign head        = mem_q[rd_ptr_q];
  assign bad         = orph_ev || (pop && cmp_err);
  assign flush_sum   = {1'b0, err_q} + {{(CNT_W-AW){1'b0}}, count_q};

`ifdef STREAM_CHECKER_TOL_EN
  localparam logic [DATA_W:0] TOL_V = TOL[DATA_W:0];
  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] mag;
  // One extra bit keeps the signed difference from overflowing.
  assign diff    = $signed({act_data_i[DATA_W-1], act_data_i}) - $signed({head[DATA_W-1], head});
  assign mag     = (diff < 0) ? -diff : diff;
  assign cmp_err = (mag > TOL_V);
`else
  logic unused_tol;
  assign unused_tol = |TOL;
  assign cmp_err    = (act_data_i != head);
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= exp_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      seen_q   <= 1'b0;
      orphan_q <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
      err_q    <= err_d;
      first_q  <= first_d;
      seen_q   <= seen_d;
      orphan_q <= orphan_d;
      mism_q   <= mism_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    total_d  = total_q;
    err_d    = err_q;
    first_d  = first_q;
    seen_d   = seen_q;
    orphan_d = orphan_q;
    mism_d   = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        if (act_valid_i) total_d = sat_inc(total_q);
        if (orph_ev)     orphan_d = 1'b1;
        if (bad) begin
          mism_d = 1'b1;
          err_d  = sat_inc(err_q);
          if (!seen_q) begin
            first_d = total_q;
            seen_d  = 1'b1;
          end
        end
        if (finish_i) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Whatever is still buffered was never matched by an actual sample.
        err_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        if (!empty && !seen_q) begin
          first_d = total_q;
          seen_d  = 1'b1;
        end
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        state_d  = S_DONE;
      end
      default: ;
    endcase
    if (start_i) begin
      state_d  = S_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      total_d  = '0;
      err_d    = '0;
      first_d  = '0;
      seen_d   = 1'b0;
      orphan_d = 1'b0;
      mism_d   = 1'b0;
    end
  end

  assign mismatch_o  = mism_q;
  assign total_cnt_o = total_q;
  assign err_cnt_o   = err_q;
  assign first_err_o = first_q;
  assign err_seen_o  = seen_q;
  assign orphan_o    = orphan_q;
  assign done_o      = (state_q == S_DONE);

endmodule
`default_nettype wire
